serial_rx: RTL

Asynchronous serial (UART-style) receiver, the receive end of the team's serial transmitter link. Each frame is 1 start bit (low), DATA_WIDTH data bits sent LSB first, and 1 stop bit (high). The line idles high. The block oversamples the line at CLOCK_DIV system clocks per bit and samples near mid-bit. It presents each received word with a one-cycle valid pulse and frame/parity status. It sits between the pad/IO input and the core consumers.

---
 rtl/serial_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/serial_rx.sv
// UART-style serial receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// LSB-first data. Define SERIAL_RX_PARITY_EN to add an even-parity bit and parity_err.
module serial_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLOCK_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  busy,
  output logic                  frame_err
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int CW = (CLOCK_DIV > 2) ? $clog2(CLOCK_DIV) : 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] HALF     = CW'(CLOCK_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(CLOCK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t                state_r;
  logic                  rx_meta_r;
  logic                  rx_s;
  logic [CW-1:0]         cnt_r;
  logic [BW-1:0]         bit_idx_r;
  logic [DATA_WIDTH-1:0] shreg_r;
`ifdef SERIAL_RX_PARITY_EN
  logic                  par_bit_r;
`endif

  // Shift one serial bit in at the MSB end so the first bit lands in bit 0.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                     input logic b);
    logic [DATA_WIDTH:0] t;
    t = {b, sr};
    return t[DATA_WIDTH:1];
  endfunction

`ifdef SERIAL_RX_PARITY_EN
  // Even parity check: a clean word plus its parity bit XORs to zero.
  function automatic logic parity_fail(input logic [DATA_WIDTH-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction
`endif

  // Two-flop synchronizer; presets to the idle (high) level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
    end
  end

  // Receive FSM with registered outputs; cnt restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= '0;
      shreg_r    <= '0;
      data       <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bit_r  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r     <= '0;
          bit_idx_r <= '0;
          if (rx_s == 1'b0) begin
            state_r <= START;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        START: begin
          if (cnt_r == HALF) begin
            cnt_r <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            if (rx_s == 1'b0) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (cnt_r == LAST) begin
            cnt_r     <= '0;
            shreg_r   <= shift_in(shreg_r, rx_s);
            bit_idx_r <= bit_idx_r + 1'b1;
            if (bit_idx_r == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
              state_r <= PARITY;
`else
              state_r <= STOP;
`endif
            end else begin
              state_r <= DATA;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (cnt_r == LAST) begin
            cnt_r     <= '0;
            par_bit_r <= rx_s;
            state_r   <= STOP;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_r == LAST) begin
            cnt_r      <= '0;
            data       <= shreg_r;
            valid      <= 1'b1;
            frame_err  <= ~rx_s;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= parity_fail(shreg_r, par_bit_r);
`endif
            busy       <= 1'b0;
            state_r    <= IDLE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
